// File: rtl/logic_sweep_pkg.sv
// Shared types, defaults and reference function for the LogicDiag sweep controller.
// The optional early-abort behaviour is selected by LOGIC_SWEEP_ABORT_ON_FAIL_EN (see top).
package logic_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StDone
    } sweep_state_t;

    localparam int unsigned N_IN_DEF          = 4;
    localparam int unsigned SETTLE_CYCLES_DEF = 2;
    localparam logic [15:0] EXPECTED_DEF      = 16'hA080;

    // Reference response of the LogicDiag block for a 4-bit drive vector
    // (v[3]=x1, v[2]=x2, v[1]=x3, v[0]=x4).
    function automatic logic ref_z(input logic [3:0] v);
        logic x1, x2, x3, x4;
        x1 = v[3];
        x2 = v[2];
        x3 = v[1];
        x4 = v[0];
        return ((x1 & x2) | (x3 & x4)) & (x2 & x4);
    endfunction

endpackage

// File: rtl/logic_sweep_ctrl.sv
// Exhaustive truth-table sweep engine for the LogicDiag block.
// Drives every input vector in ascending order, holds each for SETTLE_CYCLES cycles,
// samples z on the last held cycle and compares the captured table with EXPECTED.
// Define LOGIC_SWEEP_ABORT_ON_FAIL_EN to stop at the first sample that differs from
// EXPECTED; otherwise the full table is always captured.
module logic_sweep_ctrl
    import logic_sweep_pkg::*;
#(
    parameter int unsigned         N_IN          = N_IN_DEF,
    parameter int unsigned         SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter logic [2**N_IN-1:0]  EXPECTED      = EXPECTED_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                z_in,
    output logic [N_IN-1:0]     x_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [2**N_IN-1:0]  table_out
);

    localparam int unsigned T     = 2 ** N_IN;
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  IDX_LAST   = N_IN'(T - 1);

    sweep_state_t    state;
    logic [N_IN-1:0] idx;
    logic [CNT_W-1:0] cnt;

    logic [T-1:0]    table_next;
    logic            abort_now;
    logic            last_sample;

    // Table as it will look after the current sample, and end-of-sweep decisions.
    always_comb begin
        table_next      = table_out;
        table_next[idx] = z_in;
`ifdef LOGIC_SWEEP_ABORT_ON_FAIL_EN
        abort_now       = (z_in != EXPECTED[idx]);
`else
        abort_now       = 1'b0;
`endif
        last_sample     = abort_now || (idx == IDX_LAST);
    end

    // Sweep FSM with settle counter, vector index and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            x_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            table_out <= '0;
            idx       <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StSettle;
                        idx       <= '0;
                        x_out     <= '0;
                        cnt       <= CNT_RELOAD;
                        table_out <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                StSettle: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        table_out <= table_next;
                        if (last_sample) begin
                            // x_out keeps the final (or failing) vector through DONE.
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !abort_now && (table_next == EXPECTED);
                        end else begin
                            idx   <= idx + 1'b1;
                            x_out <= idx + 1'b1;
                            cnt   <= CNT_RELOAD;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Randomized scoreboard bench for logic_sweep_ctrl driving an inline LogicDiag block.
// A fault mask XORed onto z lets each sweep see a known-corrupted response; the model
// predicts table, pass, latency and busy length from the sweep rules.
module tb_logic_sweep_ctrl;
    import logic_sweep_pkg::*;

    localparam int          S    = 2;
    localparam int          T    = 16;
    localparam logic [15:0] GOLD = 16'hA080;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        z_in;
    logic [3:0]  x_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_out;
    logic [15:0] zmask;
    logic        diag_z;

    always #5 clk = ~clk;

    // LogicDiag block: x1..x4 from x_out[3..0].
    assign diag_z = ((x_out[3] & x_out[2]) | (x_out[1] & x_out[0])) & (x_out[2] & x_out[0]);
    assign z_in   = diag_z ^ zmask[x_out];

    logic_sweep_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .z_in      (z_in),
        .x_out     (x_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .table_out (table_out)
    );

    typedef struct {
        logic [15:0] tbl;
        logic        pass;
        int          nvec;
        int          busy;
        int          lat;
        logic [3:0]  last_x;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    endtask

    // Expected result of one sweep, derived from the sweep rules.
    function automatic exp_t model(input logic [15:0] mask);
        exp_t e;
        e.tbl  = '0;
        e.nvec = T;
        for (int i = 0; i < T; i++) begin
            logic b;
            b        = ref_z(4'(i)) ^ mask[i];
            e.tbl[i] = b;
`ifdef LOGIC_SWEEP_ABORT_ON_FAIL_EN
            if (b != GOLD[i]) begin
                e.nvec = i + 1;
                break;
            end
`endif
        end
        e.pass   = (e.tbl == GOLD);
        e.busy   = e.nvec * S;
        e.lat    = e.busy + 1;
        e.last_x = 4'(e.nvec - 1);
        return e;
    endfunction

    // Monitor: tracks busy window and x_out sequence, checks each done against the scoreboard.
    int         cyc = 0;
    int         first_busy = 0;
    int         busy_cnt = 0;
    logic       prev_busy = 1'b0;
    logic       after_done = 1'b0;
    logic       last_pass = 1'b0;
    logic [3:0] xs[$];
    exp_t       me;

    always @(negedge clk) begin
        int bad;
        cyc++;
        if (after_done) begin
            check("done_one_cycle", {31'd0, done}, 32'd0);
            check("pass_hold", {31'd0, pass}, {31'd0, last_pass});
            after_done = 1'b0;
        end
        if (busy && !prev_busy) begin
            first_busy = cyc;
            busy_cnt   = 0;
            xs.delete();
        end
        if (busy) begin
            busy_cnt++;
            xs.push_back(x_out);
        end
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1, expected no done (t=%0t)", $time);
            end else begin
                me = sb.pop_front();
                check("table_out", 32'(table_out), 32'(me.tbl));
                check("pass", {31'd0, pass}, {31'd0, me.pass});
                check("latency", cyc - first_busy + 1, me.lat);
                check("busy_len", busy_cnt, me.busy);
                check("busy_in_done", {31'd0, busy}, 32'd0);
                check("x_out_in_done", 32'(x_out), 32'(me.last_x));
                bad = -1;
                if (xs.size() != me.busy) bad = xs.size();
                else begin
                    for (int k = 0; k < xs.size(); k++) begin
                        if (bad < 0 && xs[k] != 4'(k / S)) bad = k;
                    end
                end
                check("x_seq_first_bad", bad, -1);
                last_pass  = me.pass;
                after_done = 1'b1;
            end
        end
        prev_busy = busy;
    end

    bit chained = 1'b0;

    // One sweep. tail: 0 = start low after done, 1 = start only in DONE cycle,
    // 2 = start held into the cycle after done (back-to-back sweep).
    task automatic do_sweep(input logic [15:0] mask, input bit noise, input int tail);
        exp_t e;
        int   w;
        e = model(mask);
        sb.push_back(e);
        zmask = mask;
        if (!chained) begin
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end else begin
            @(posedge clk);
            @(posedge clk); #1 start = 1'b0;
            chained = 1'b0;
        end
        w = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            w++;
            if (w > 200) begin
                n_checks++;
                $display("FAIL done_timeout: got no done in 200 cycles, expected done");
                start = 1'b0;
                return;
            end
            if (noise) start = ($urandom_range(0, 5) == 0);
        end
        case (tail)
            1: begin
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check("no_restart_from_done", {31'd0, busy}, 32'd0);
            end
            2: begin
                start   = 1'b1;
                chained = 1'b1;
            end
            default: start = 1'b0;
        endcase
    endtask

    // Abandon a sweep with reset while vector 7 is driven.
    task automatic reset_mid_sweep();
        int w;
        zmask = '0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (x_out != 4'd7 && w < 100);
        check("reached_x7", 32'(x_out), 32'd7);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_x_out", 32'(x_out), 32'd0);
        check("rst_table", 32'(table_out), 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("rst_no_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        int          sel;
        rst   = 1'b1;
        start = 1'b0;
        zmask = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_pass", {31'd0, pass}, 32'd0);
        check("reset_x_out", 32'(x_out), 32'd0);
        check("reset_table", 32'(table_out), 32'd0);

        do_sweep(16'h0000, 1'b0, 0);   // clean block
        do_sweep(GOLD, 1'b0, 0);       // z stuck at 0
        do_sweep(16'h0000, 1'b1, 1);   // stray starts, start in DONE only
        do_sweep(~GOLD, 1'b1, 2);      // z stuck at 1, then back-to-back
        do_sweep(GOLD, 1'b0, 0);       // must begin from a cleared table
        reset_mid_sweep();
        do_sweep(16'h0000, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: m = 16'h0000;
                1: m = 16'(1 << $urandom_range(0, 15));
                default: m = 16'($urandom);
            endcase
            do_sweep(m, 1'($urandom_range(0, 1)), (i == 7) ? 0 : $urandom_range(0, 2));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_sweep_ctrl.md
Name: logic_sweep_ctrl

Overview:
Sequential stimulus/response engine on the driving side of the 4-input LogicDiag dataflow block (z = ((x1&x2)|(x3&x4)) & (x2&x4)).
- On start, drives all 2^N_IN input vectors in ascending order and waits a fixed settle time per vector.
- Samples z into a truth-table register and compares the full table with an expected word.
- Reports done/pass to a host controller or bench.

Parameters:
- N_IN, 4, number of driven inputs; truth-table width T = 2**N_IN.
- SETTLE_CYCLES, 2, cycles each vector is held (>=1); z is sampled on the last held cycle.
- EXPECTED, 16'hA080, golden truth table; bit i = z for x_out == i. Width T.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request sweep; accepted only in IDLE.
- z_in  in  1  response from the logic block.
- x_out  out  N_IN  drive vector: x_out[3]=x1, [2]=x2, [1]=x3, [0]=x4.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse at end of sweep.
- pass  out  1  table_out == EXPECTED; valid from done, held until next accepted start.
- table_out  out  T  captured truth table.

Behaviour:
- Reset (rst=1 at edge, any state, including mid-sweep) sets state=IDLE, x_out=0, busy=0, done=0, pass=0, table_out=0, idx=0, cnt=0. No partial result is kept.
- FSM states: IDLE, SETTLE, DONE. All outputs are registered.
- IDLE, start=1: next state SETTLE. Set idx=0, x_out=0, cnt=SETTLE_CYCLES-1, table_out=0, pass=0, busy=1.
- SETTLE, cnt!=0: cnt decrements; x_out is held.
- SETTLE, cnt==0: table_out[idx] <= z_in.
  - If idx==T-1, next state is DONE.
  - Otherwise idx++, x_out <= idx+1, cnt reloads to SETTLE_CYCLES-1.
- DONE, one cycle only:
  - done=1, busy=0.
  - pass registered on entry to DONE, computed from the final table including the last sample.
  - Next state IDLE.
- Each vector is held for exactly SETTLE_CYCLES cycles. x_out changes only at vector boundaries, so it is glitch-free.
- Latency: start accepted at edge k gives done=1 in cycle k+1+T*SETTLE_CYCLES. Default: 33 cycles.
- start while in SETTLE or DONE is ignored; no queuing. start must be seen again in IDLE.
- idx and cnt never wrap: sweep ends at T-1.
- When SETTLE_CYCLES=1, every SETTLE cycle is a sample cycle.

Optional Feature:
- Macro: LOGIC_SWEEP_ABORT_ON_FAIL_EN.
- Defined: in SETTLE with cnt==0, if z_in != EXPECTED[idx], the sample is still stored and the FSM goes directly to DONE with pass=0. table_out bits above idx stay 0, and x_out holds the failing vector for the DONE cycle.
- Undefined: always a full T-vector sweep; pass is evaluated only at the end.

Decomposition:
- Package logic_sweep_pkg holds:
  - state typedef (IDLE, SETTLE, DONE);
  - localparam defaults: N_IN=4, SETTLE_CYCLES=2, EXPECTED=16'hA080;
  - function computing the reference z for a 4-bit index, used by the bench and for deriving EXPECTED.
- No internal sub-module; the settle counter and index are inline.
- The bench instantiates logic_sweep_ctrl and the LogicDiag block back-to-back (x_out -> x1..x4, z -> z_in).

Test Plan:
1. Reset, then 1-cycle start, with z_in from LogicDiag and defaults -> done at cycle 33, table_out=16'hA080, pass=1, busy high for exactly 32 cycles.
2. Cycle-by-cycle monitor of x_out -> values 0..15 in order, each held exactly 2 cycles; sampled bits 7, 13 and 15 equal 1, all others 0.
3. z_in tied 0 -> table_out=16'h0000, pass=0; done still at cycle 33.
4. Extra start pulses at cycles 5 and 20 and in the DONE cycle -> no restart, timing unchanged; a start 1 cycle after done starts a fresh sweep with table_out cleared.
5. rst asserted while x_out=7 -> next cycle busy=0, x_out=0, table_out=0, pass=0, no done; a following start gives a full 33-cycle sweep and pass=1.
6. LOGIC_SWEEP_ABORT_ON_FAIL_EN defined, z_in stuck 1 -> mismatch at idx 0; done in cycle 3 after start, table_out=16'h0001, pass=0, x_out=0.
